// File: rtl/vec_pkg.sv
// Shared types and constants for the SIMD execute stage.
package vec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  // Bit positions inside the 4-bit {N,Z,C,V} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DEF_LANES  = 16;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;

  // Assemble a flag word from its individual bits.
  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] r;
    r         = 4'b0000;
    r[FLAG_N] = n;
    r[FLAG_Z] = z;
    r[FLAG_C] = c;
    r[FLAG_V] = v;
    return r;
  endfunction

endpackage

// File: rtl/vec_alu_pipe_if.sv
// Operand/result bundle between the decode/execute register and the SIMD stage.
interface vec_alu_pipe_if #(
  parameter int LANES = vec_pkg::DEF_LANES,
  parameter int WIDTH = vec_pkg::DEF_WIDTH
) ();
  import vec_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  alu_op_e                op;
  logic                   vec_scalar;
  logic [LANES*WIDTH-1:0] src_a;
  logic [LANES*WIDTH-1:0] src_b;
  logic [WIDTH-1:0]       imm;
  logic                   use_imm;
  logic                   imm_bcast;
  logic [LANES-1:0]       lane_mask;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] result;
  logic [3:0]             flags;
  logic [LANES-1:0]       lane_zero;
  logic [31:0]            ops_retired;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, op, vec_scalar, src_a, src_b, imm, use_imm, imm_bcast,
           lane_mask, flush, out_ready,
    input  in_ready, out_valid, result, flags, lane_zero, ops_retired
  );

  // The execute stage itself.
  modport slave (
    input  in_valid, op, vec_scalar, src_a, src_b, imm, use_imm, imm_bcast,
           lane_mask, flush, out_ready,
    output in_ready, out_valid, result, flags, lane_zero, ops_retired
  );

endinterface

// File: rtl/vec_lane_alu.sv
// One combinational SIMD lane: computes result and {N,Z,C,V}; an inactive
// lane passes operand A through with all flags cleared.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             active,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       nzcv
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] val_s;
  logic             c_s;
  logic             v_s;

  // Extra top bit carries the carry-out / borrow.
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign sh_s   = b[SHW-1:0];
  assign prod_s = a * b;

  // Operation select with carry and signed-overflow only for ADD/SUB.
  always_comb begin
    val_s = a;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op)
      OP_ADD: begin
        val_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        val_s = diff_s[WIDTH-1:0];
        c_s   = ~diff_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  val_s = a & b;
      OP_ORR:  val_s = a | b;
      OP_EOR:  val_s = a ^ b;
      OP_LSL:  val_s = a << sh_s;
      OP_LSR:  val_s = a >> sh_s;
      OP_MUL:  val_s = prod_s;
      default: val_s = a;
    endcase
  end

  // Lane enable: inactive lanes are transparent and report no flags.
  always_comb begin
    res  = a;
    nzcv = 4'b0000;
    if (active) begin
      res  = val_s;
      nzcv = pack_nzcv(val_s[WIDTH-1], (val_s == {WIDTH{1'b0}}), c_s, v_s);
    end else begin
      res  = a;
      nzcv = 4'b0000;
    end
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// N-lane SIMD execute stage: combinational lane ALUs at entry followed by
// STAGES elastic register stages with valid/ready backpressure and flush.
module vec_alu_pipe
  import vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic          clk,
  input logic          rst,
  vec_alu_pipe_if.slave bus
);

  localparam int TOP = LANES - 1;
  localparam int DW  = LANES * WIDTH;
  localparam int LST = STAGES - 1;

  logic [DW-1:0]    b_sel_s;
  logic [DW-1:0]    res_s;
  logic [LANES-1:0] active_s;
  logic [LANES-1:0] lz_s;
  logic [3:0]       nzcv_s [LANES];

  logic [STAGES-1:0] vld_r;
  logic [DW-1:0]     res_r [STAGES];
  logic [3:0]        flg_r [STAGES];
  logic [LANES-1:0]  lz_r  [STAGES];
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] load_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              retire_s;
  logic [31:0]       retired_r;

  // Operand B routing (register, broadcast immediate, or scalar immediate)
  // and per-lane enable; scalar ops only ever touch the top lane.
  always_comb begin
    b_sel_s  = {DW{1'b0}};
    active_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (bus.use_imm) begin
        if (bus.imm_bcast || (i == TOP)) begin
          b_sel_s[i*WIDTH +: WIDTH] = bus.imm;
        end else begin
          b_sel_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        end
      end else begin
        b_sel_s[i*WIDTH +: WIDTH] = bus.src_b[i*WIDTH +: WIDTH];
      end
      if (bus.vec_scalar) begin
        active_s[i] = bus.lane_mask[i];
      end else begin
        active_s[i] = (i == TOP);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (bus.src_a[g*WIDTH +: WIDTH]),
        .b      (b_sel_s[g*WIDTH +: WIDTH]),
        .op     (bus.op),
        .active (active_s[g]),
        .res    (res_s[g*WIDTH +: WIDTH]),
        .nzcv   (nzcv_s[g])
      );
      assign lz_s[g] = nzcv_s[g][FLAG_Z];
    end
  endgenerate

  // Backpressure chain: a stage moves on when its successor is empty or
  // moving itself; a stage can load when it is empty or moving on.
  always_comb begin
    adv_s      = {STAGES{1'b0}};
    load_s     = {STAGES{1'b0}};
    adv_s[LST] = bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_s[k] = !vld_r[k+1] || adv_s[k+1];
    end
    for (int k = 0; k < STAGES; k++) begin
      load_s[k] = !vld_r[k] || adv_s[k];
    end
  end

  assign in_ready_s = !rst && !bus.flush && load_s[0];
  assign accept_s   = bus.in_valid && in_ready_s;
  assign retire_s   = vld_r[LST] && bus.out_ready;

  // Stage valid bits; flush empties the whole pipe in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {STAGES{1'b0}};
    end else if (bus.flush) begin
      vld_r <= {STAGES{1'b0}};
    end else begin
      if (load_s[0]) begin
        vld_r[0] <= accept_s;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load_s[k]) begin
          vld_r[k] <= vld_r[k-1];
        end
      end
    end
  end

  // Stage payloads: only overwritten when real data moves in, so a stalled
  // last stage keeps its result stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        res_r[k] <= {DW{1'b0}};
        flg_r[k] <= 4'b0000;
        lz_r[k]  <= {LANES{1'b0}};
      end
    end else begin
      if (accept_s) begin
        res_r[0] <= res_s;
        flg_r[0] <= nzcv_s[TOP];
        lz_r[0]  <= lz_s;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load_s[k] && vld_r[k-1]) begin
          res_r[k] <= res_r[k-1];
          flg_r[k] <= flg_r[k-1];
          lz_r[k]  <= lz_r[k-1];
        end
      end
    end
  end

  // Count results taken downstream, including one taken during a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= 32'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = vld_r[LST];
  assign bus.result      = res_r[LST];
  assign bus.flags       = flg_r[LST];
  assign bus.lane_zero   = lz_r[LST];
  assign bus.ops_retired = retired_r;

endmodule

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
Parametrised N-lane SIMD execute stage: the next generation of the core's fixed 16-lane execute ALU bank.
- Adds configurable lane count, data width and pipeline depth.
- Adds a valid/ready elastic handshake with backpressure, per-lane write mask, immediate broadcast, flush, and a retired-op counter.
- Sits between the decode/execute pipe register and the execute/memory pipe register; scalar ops use the top lane only.

Parameters:
LANES, 16, number of vector lanes (1..32)
WIDTH, 32, lane data width in bits (8..64, power of 2)
STAGES, 2, register stages from accept to output (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
op  in  3  ALU operation (vec_pkg::alu_op_e)
vec_scalar  in  1  1 = vector, 0 = scalar (lane LANES-1 only)
src_a  in  LANES*WIDTH  operand A, lane i at [i]
src_b  in  LANES*WIDTH  operand B register values
imm  in  WIDTH  extended immediate
use_imm  in  1  B = immediate instead of src_b
imm_bcast  in  1  1 = imm to all lanes; 0 = imm to lane LANES-1, other lanes B = 0
lane_mask  in  LANES  active lanes (vector mode)
flush  in  1  discard all in-flight ops
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
result  out  LANES*WIDTH  lane results
flags  out  4  {N,Z,C,V} of lane LANES-1
lane_zero  out  LANES  per-lane Z
ops_retired  out  32  count of results consumed downstream

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All stage valid bits = 0, result = 0, flags = 0, lane_zero = 0, ops_retired = 0.
  - in_ready = 0 while rst is high.
- Ops:
  - 000 ADD; 001 SUB (A-B); 010 AND; 011 ORR; 100 EOR.
  - 101 LSL, 110 LSR: amount = B[$clog2(WIDTH)-1:0].
  - 111 MUL: low WIDTH bits.
- Flags per lane:
  - N = res[WIDTH-1]; Z = (res == 0).
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = 1 when A >= B unsigned (no borrow), V = signed overflow.
  - Logic, shift and MUL ops: C = V = 0.
- Lane enable:
  - Vector mode: lane i active iff lane_mask[i].
  - Scalar mode: only lane LANES-1 is active; lane_mask is ignored.
  - Inactive lanes output src_a unchanged, with lane_zero[i] = 0.
- Compute/pipeline:
  - Result is computed combinationally at entry and captured into stage 1 on accept.
  - Stages 2..STAGES are elastic registers; each stage holds {valid, result, flags, lane_zero}.
  - out_valid/result/flags/lane_zero are driven from the last stage.
- Handshake:
  - Stage k advances when its successor is empty or advancing; the last stage advances when out_ready.
  - in_ready = !rst && !flush && (stage1 empty || stage1 advancing).
  - Full throughput is one op per cycle. Latency is exactly STAGES cycles from accept to out_valid with out_ready held high.
  - While out_valid && !out_ready: result/flags/lane_zero hold stable. No op is dropped or duplicated.
  - Once asserted, out_valid stays high until consumed or flushed.
- Flush:
  - All valid bits clear at the next edge; in_valid is ignored that cycle.
  - A result consumed in the flush cycle still counts.
  - flush and rst together behave as rst.
- ops_retired:
  - Increments on out_valid && out_ready && !rst.
  - Wraps 0xFFFF_FFFF -> 0.
- Widths: all arithmetic is mod 2^WIDTH; the MUL product is truncated.

Decomposition:
- vec_pkg:
  - alu_op_e enum (3 bits).
  - Flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - Default LANES/WIDTH constants.
- Sub-module vec_lane_alu: combinational, one lane.
  - Inputs: a, b, op, active.
  - Outputs: res, nzcv.
  - Instantiated LANES times via generate.
  - The pipeline/handshake logic stays in vec_alu_pipe.

Test Plan:
- Vector ADD:
  - Stimulus: LANES=16, STAGES=2, src_a[i] = i, src_b[i] = 0x10, mask = 0xFFFF, out_ready = 1.
  - Response: out_valid exactly 2 cycles after accept; result[i] = 0x10+i; lane_zero = 0; ops_retired = 1.
- Scalar SUB with immediate:
  - Stimulus: vec_scalar = 0, src_a[15] = 5, use_imm = 1, imm_bcast = 0, imm = 5.
  - Response: result[15] = 0; flags = 4'b0110 (Z, C); lanes 0..14 equal src_a.
- Overflow and mask:
  - Stimulus: ADD 0x7FFFFFFF + 1 on lane 15 in vector mode with mask = 0x8001.
  - Response: flags = 4'b1001 (N, V); lane 0 computed; lanes 1..14 pass src_a through.
- Backpressure:
  - Stimulus: stream 6 ops with op = LSL and B = i.
  - Hold out_ready = 0 for 4 cycles mid-stream.
  - Response: in_ready drops after STAGES ops are held; outputs stay stable; all 6 results arrive in order; ops_retired = 6.
- Flush and reset mid-flight:
  - Stimulus: flush with 2 ops in flight. Then, in a later run, assert rst while out_valid = 1.
  - Response: after flush, out_valid = 0 next cycle and ops_retired is unchanged. After rst, all outputs = 0.
- Counter wrap:
  - Stimulus: force ops_retired = 0xFFFF_FFFF, then one handshake.
  - Response: ops_retired = 0.
